// File: rtl/i2c_master_tx.sv
// i2c_master_tx: I2C master write engine that drains an afifo read port on clk_30M.
// Define CLOCK_STRETCH_EN to let a slave hold SCL low and stall the SCL high phase.
module i2c_master_tx #(
    parameter int QDIV = 75,
    parameter int CNTW = 8
) (
    input  logic            clk_30M,
    input  logic            nReset,
    input  logic            i_en,
    input  logic [6:0]      i_addr,
    input  logic            i_rempty,
    input  logic [7:0]      i_rdata,
    output logic            o_rd,
    input  logic            i_scl,
    input  logic            i_sda,
    output logic            o_scl_oe,
    output logic            o_sda_oe,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_nack,
    output logic [CNTW-1:0] o_tx_count
);

    typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_t;

    state_t     state;
    logic [7:0] qcnt;
    logic [1:0] q;
    logic [2:0] bit_idx;
    logic [7:0] shifter;
    logic [6:0] addr_q;
    logic       ack_n;
    logic [1:0] sda_sync;
    logic       freeze;
    logic       ack_slot;

    assign ack_slot = (state == ADDR_ACK) || (state == DATA_ACK);

    always_ff @(posedge clk_30M or negedge nReset) begin
        if (!nReset) begin
            sda_sync <= 2'b11;
        end else begin
            sda_sync <= {sda_sync[0], i_sda};
        end
    end

`ifdef CLOCK_STRETCH_EN
    logic [1:0] scl_sync;

    always_ff @(posedge clk_30M or negedge nReset) begin
        if (!nReset) begin
            scl_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i_scl};
        end
    end

    // SCL still low after we released it means a slave is stretching the clock.
    assign freeze = ((q == 2'd1) || (q == 2'd2)) && !scl_sync[1] && !o_scl_oe;
`else
    logic unused_scl;
    assign unused_scl = i_scl;
    assign freeze     = 1'b0;
`endif

    // Open-drain enables {scl_oe, sda_oe} for a given state, quarter and data bit.
    function automatic logic [1:0] drive(input state_t st, input logic [1:0] qq, input logic b);
        logic scl_low;
        scl_low = (qq == 2'd0) || (qq == 2'd3);
        case (st)
            START:              return (qq == 2'd0) ? 2'b00 : (qq == 2'd1) ? 2'b01 : 2'b11;
            ADDR, DATA:         return {scl_low, ~b};
            ADDR_ACK, DATA_ACK: return {scl_low, 1'b0};
            STOP:               return (qq == 2'd0) ? 2'b11 : (qq == 2'd1) ? 2'b01 : 2'b00;
            default:            return 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk_30M or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            qcnt       <= 8'd0;
            q          <= 2'd0;
            bit_idx    <= 3'd0;
            shifter    <= 8'd0;
            addr_q     <= 7'd0;
            ack_n      <= 1'b1;
            o_rd       <= 1'b0;
            o_scl_oe   <= 1'b0;
            o_sda_oe   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_nack     <= 1'b0;
            o_tx_count <= '0;
        end else begin
            o_rd   <= 1'b0;
            o_done <= 1'b0;
            if (state == IDLE) begin
                qcnt <= 8'd0;
                q    <= 2'd0;
                if (!i_rempty && i_en) begin
                    state                <= START;
                    addr_q               <= i_addr;
                    o_busy               <= 1'b1;
                    o_nack               <= 1'b0;
                    o_tx_count           <= '0;
                    {o_scl_oe, o_sda_oe} <= drive(START, 2'd0, 1'b0);
                end
            end else if (freeze) begin
                qcnt <= qcnt;
            end else if (qcnt != 8'(QDIV - 1)) begin
                qcnt <= qcnt + 8'd1;
            end else begin
                qcnt <= 8'd0;
                q    <= q + 2'd1;
                if (ack_slot && (q == 2'd2)) begin
                    ack_n <= sda_sync[1];
                end
                if (q != 2'd3) begin
                    {o_scl_oe, o_sda_oe} <= drive(state, q + 2'd1, shifter[7]);
                end else begin
                    case (state)
                        START: begin
                            state                <= ADDR;
                            shifter              <= {addr_q, 1'b0};
                            bit_idx              <= 3'd0;
                            {o_scl_oe, o_sda_oe} <= drive(ADDR, 2'd0, addr_q[6]);
                        end
                        ADDR, DATA: begin
                            if (bit_idx == 3'd7) begin
                                state                <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                                {o_scl_oe, o_sda_oe} <= drive(ADDR_ACK, 2'd0, 1'b0);
                            end else begin
                                bit_idx              <= bit_idx + 3'd1;
                                shifter              <= {shifter[6:0], 1'b0};
                                {o_scl_oe, o_sda_oe} <= drive(state, 2'd0, shifter[6]);
                            end
                        end
                        ADDR_ACK, DATA_ACK: begin
                            if ((state == DATA_ACK) && !ack_n) begin
                                o_tx_count <= o_tx_count + CNTW'(1);
                            end
                            // NACK wins over everything, then running dry or being disabled.
                            if (ack_n) begin
                                o_nack               <= 1'b1;
                                state                <= STOP;
                                {o_scl_oe, o_sda_oe} <= drive(STOP, 2'd0, 1'b0);
                            end else if (!i_en || i_rempty) begin
                                state                <= STOP;
                                {o_scl_oe, o_sda_oe} <= drive(STOP, 2'd0, 1'b0);
                            end else begin
                                state                <= DATA;
                                shifter              <= i_rdata;
                                bit_idx              <= 3'd0;
                                o_rd                 <= 1'b1;
                                {o_scl_oe, o_sda_oe} <= drive(DATA, 2'd0, i_rdata[7]);
                            end
                        end
                        STOP: begin
                            state                <= IDLE;
                            o_busy               <= 1'b0;
                            o_done               <= 1'b1;
                            {o_scl_oe, o_sda_oe} <= 2'b00;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_tx.sv
// tb_i2c_master_tx: table-driven and randomized bench for i2c_master_tx with a
// behavioural I2C slave, bus monitor and FIFO model.
`timescale 1ns/1ps
module tb_i2c_master_tx;

    localparam int QDIV = 4;
    localparam int CNTW = 3;

    logic            clk_30M;
    logic            nReset;
    logic            i_en;
    logic [6:0]      i_addr;
    logic            i_rempty;
    logic [7:0]      i_rdata;
    logic            o_rd;
    logic            i_scl;
    logic            i_sda;
    logic            o_scl_oe;
    logic            o_sda_oe;
    logic            o_busy;
    logic            o_done;
    logic            o_nack;
    logic [CNTW-1:0] o_tx_count;

    i2c_master_tx #(.QDIV(QDIV), .CNTW(CNTW)) dut (
        .clk_30M    (clk_30M),
        .nReset     (nReset),
        .i_en       (i_en),
        .i_addr     (i_addr),
        .i_rempty   (i_rempty),
        .i_rdata    (i_rdata),
        .o_rd       (o_rd),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_scl_oe   (o_scl_oe),
        .o_sda_oe   (o_sda_oe),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_nack     (o_nack),
        .o_tx_count (o_tx_count)
    );

    initial clk_30M = 1'b0;
    always #5 clk_30M = ~clk_30M;

    typedef struct {
        logic [6:0] addr;
        int         n;
        logic [7:0] first;
        logic [7:0] step;
        int         nackAt;
        int         dropAt;
        int         expPops;
        int         expCount;
        int         expNack;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] fifo[$];
    logic [7:0] rxBytes[$];
    logic [7:0] expData[$];
    logic [7:0] curByte;
    logic       prevScl, prevSda, prevOe, slavePull, scl, sda;
    int         vectors, miscompares;
    int         hold, bitCnt, pops, badPop, startCount, stopCount, doneCount;
    int         nackAt, dropAt, busyAtStart, cycleCnt, lastCycles;
`ifdef CLOCK_STRETCH_EN
    logic       stretchArm;
    int         baseCycles;
`endif

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic syncFifoPins();
        i_rempty = (fifo.size() == 0);
        i_rdata  = (fifo.size() == 0) ? 8'h00 : fifo[0];
    endtask

    task automatic loadWords(input logic [7:0] first, input logic [7:0] step, input int n);
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            w = first + step * 8'(i);
            fifo.push_back(w);
        end
        syncFifoPins();
    endtask

    // One clock of the outside world: FIFO pops, slave, stretching and the bus monitor.
    task automatic stepCycle();
        @(negedge clk_30M);
        cycleCnt++;
        if (o_done) doneCount++;
        if (o_rd) begin
            pops++;
            if (fifo.size() == 0) badPop++;
            else void'(fifo.pop_front());
        end
        if (hold > 0) hold--;
`ifdef CLOCK_STRETCH_EN
        if (stretchArm && rxBytes.size() == 1 && bitCnt == 1 && prevOe && !o_scl_oe) begin
            hold       = 20;
            stretchArm = 1'b0;
        end
`endif
        prevOe = o_scl_oe;
        scl    = !(o_scl_oe || hold > 0);
        sda    = !(o_sda_oe || slavePull);
        if (prevScl && scl && prevSda && !sda) begin
            startCount++;
            busyAtStart = int'(o_busy);
            bitCnt      = 0;
        end else if (prevScl && scl && !prevSda && sda) begin
            stopCount++;
        end else if (!prevScl && scl) begin
            if (bitCnt < 8) curByte = {curByte[6:0], sda};
            bitCnt++;
        end else if (prevScl && !scl) begin
            if (bitCnt == 8) begin
                rxBytes.push_back(curByte);
                slavePull = ((rxBytes.size() - 1) != nackAt);
            end else if (bitCnt == 9) begin
                slavePull = 1'b0;
                bitCnt    = 0;
            end
        end
        if (dropAt > 0 && rxBytes.size() == dropAt && bitCnt == 3) i_en = 1'b0;
        sda     = !(o_sda_oe || slavePull);
        i_sda   = sda;
        i_scl   = scl;
        prevScl = scl;
        prevSda = sda;
        syncFifoPins();
    endtask

    // Outcome of one burst from the protocol rules alone: who NACKs and how much was queued.
    task automatic refModel(input int n, input int nack, output int p, output int c, output int k);
        if (nack <= n) begin
            p = nack;
            c = (nack > 0) ? nack - 1 : 0;
            k = 1;
        end else begin
            p = n;
            c = n;
            k = 0;
        end
        c = c % (1 << CNTW);
    endtask

    task automatic applyStimulus(input string name, input logic [6:0] addr, input int expPops,
                                 input int expCount, input int expNack, input int expRemain);
        int c0;
        int got;
        expData.delete();
        for (int i = 0; i < expPops && i < fifo.size(); i++) expData.push_back(fifo[i]);
        rxBytes.delete();
        pops        = 0;
        startCount  = 0;
        stopCount   = 0;
        doneCount   = 0;
        bitCnt      = 0;
        slavePull   = 1'b0;
        busyAtStart = 0;
        c0          = cycleCnt;
        i_addr      = addr;
        i_en        = 1'b1;
        for (int c = 0; c < 4000 && doneCount == 0; c++) begin
            stepCycle();
            if (startCount > 0) i_addr = ~addr;
        end
        lastCycles = cycleCnt - c0;
        checkOutput({name, " done seen"}, (doneCount > 0) ? 1 : 0, 1);
        i_en = 1'b0;
        repeat (4) stepCycle();
        checkOutput({name, " byte count"}, rxBytes.size(), expPops + 1);
        checkOutput({name, " addr byte"}, (rxBytes.size() > 0) ? int'(rxBytes[0]) : -1, int'({addr, 1'b0}));
        for (int i = 0; i < expData.size(); i++) begin
            got = (i + 1 < rxBytes.size()) ? int'(rxBytes[i + 1]) : -1;
            checkOutput($sformatf("%s data%0d", name, i), got, int'(expData[i]));
        end
        checkOutput({name, " tx_count"}, int'(o_tx_count), expCount);
        checkOutput({name, " nack"}, int'(o_nack), expNack);
        checkOutput({name, " pops"}, pops, expPops);
        checkOutput({name, " fifo left"}, fifo.size(), expRemain);
        checkOutput({name, " starts"}, startCount, 1);
        checkOutput({name, " stops"}, stopCount, 1);
        checkOutput({name, " done pulses"}, doneCount, 1);
        checkOutput({name, " busy at start"}, busyAtStart, 1);
        checkOutput({name, " busy after"}, int'(o_busy), 0);
        checkOutput({name, " bus released"}, int'(o_scl_oe | o_sda_oe), 0);
    endtask

    initial begin
        int         eP, eC, eN;
        int         n, na;
        logic [6:0] a;

        vecs[0] = '{7'h50, 1, 8'hA5, 8'h00, 99, 0, 1, 1, 0};
        vecs[1] = '{7'h2C, 3, 8'h01, 8'h01, 99, 0, 3, 3, 0};
        vecs[2] = '{7'h11, 1, 8'h3C, 8'h00, 0,  0, 0, 0, 1};
        vecs[3] = '{7'h7F, 3, 8'h80, 8'h11, 2,  0, 2, 1, 1};
        vecs[4] = '{7'h00, 3, 8'hFF, 8'hF0, 99, 1, 1, 1, 0};
        vecs[5] = '{7'h3A, 9, 8'h40, 8'h03, 99, 0, 9, 1, 0};

        vectors = 0; miscompares = 0; hold = 0; bitCnt = 0; pops = 0; badPop = 0;
        startCount = 0; stopCount = 0; doneCount = 0; nackAt = 99; dropAt = 0;
        busyAtStart = 0; cycleCnt = 0; lastCycles = 0; curByte = 8'h00;
        prevScl = 1'b1; prevSda = 1'b1; prevOe = 1'b0; slavePull = 1'b0; scl = 1'b1; sda = 1'b1;
`ifdef CLOCK_STRETCH_EN
        stretchArm = 1'b0; baseCycles = 0;
`endif
        nReset = 1'b0; i_en = 1'b0; i_addr = 7'h00; i_scl = 1'b1; i_sda = 1'b1;
        syncFifoPins();

        repeat (2) stepCycle();
        checkOutput("reset scl_oe", int'(o_scl_oe), 0);
        checkOutput("reset sda_oe", int'(o_sda_oe), 0);
        checkOutput("reset busy", int'(o_busy), 0);
        checkOutput("reset done", int'(o_done), 0);
        checkOutput("reset nack", int'(o_nack), 0);
        checkOutput("reset rd", int'(o_rd), 0);
        checkOutput("reset tx_count", int'(o_tx_count), 0);
        nReset = 1'b1;
        repeat (2) stepCycle();

        for (int v = 0; v < 6; v++) begin
            fifo.delete();
            loadWords(vecs[v].first, vecs[v].step, vecs[v].n);
            nackAt = vecs[v].nackAt;
            dropAt = vecs[v].dropAt;
            applyStimulus($sformatf("vec%0d", v), vecs[v].addr, vecs[v].expPops,
                          vecs[v].expCount, vecs[v].expNack, vecs[v].n - vecs[v].expPops);
        end
        fifo.delete();
        syncFifoPins();
        nackAt = 99;
        dropAt = 0;

        // Word shows up long after the FIFO ran dry: the old burst is over, a new one starts.
        i_en       = 1'b1;
        startCount = 0;
        repeat (48) stepCycle();
        checkOutput("late word no start while empty", startCount, 0);
        checkOutput("late word idle busy", int'(o_busy), 0);
        loadWords(8'h77, 8'h00, 1);
        applyStimulus("late word", 7'h2B, 1, 1, 0, 0);

        // Reset in the middle of data bit 4, then a fresh burst for the remaining word.
        loadWords(8'hC3, 8'h79, 2);
        rxBytes.delete();
        bitCnt    = 0;
        slavePull = 1'b0;
        i_addr    = 7'h24;
        i_en      = 1'b1;
        for (int c = 0; c < 3000 && !(rxBytes.size() == 1 && bitCnt == 4 && o_scl_oe); c++) stepCycle();
        checkOutput("reset point scl driven", int'(o_scl_oe), 1);
        nReset = 1'b0;
        #1;
        checkOutput("mid reset scl_oe", int'(o_scl_oe), 0);
        checkOutput("mid reset sda_oe", int'(o_sda_oe), 0);
        checkOutput("mid reset busy", int'(o_busy), 0);
        repeat (3) stepCycle();
        slavePull = 1'b0;
        nReset    = 1'b1;
        applyStimulus("after reset", 7'h24, 1, 1, 0, 0);

        for (int r = 0; r < 12; r++) begin
            n  = $urandom_range(1, 6);
            a  = 7'($urandom);
            na = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : 99;
            fifo.delete();
            for (int i = 0; i < n; i++) fifo.push_back(8'($urandom));
            syncFifoPins();
            refModel(n, na, eP, eC, eN);
            nackAt = na;
            dropAt = 0;
            applyStimulus($sformatf("rand%0d", r), a, eP, eC, eN, n - eP);
        end
        fifo.delete();
        syncFifoPins();
        nackAt = 99;

`ifdef CLOCK_STRETCH_EN
        loadWords(8'h5A, 8'h00, 1);
        applyStimulus("stretch base", 7'h33, 1, 1, 0, 0);
        baseCycles = lastCycles;
        loadWords(8'h5A, 8'h00, 1);
        stretchArm = 1'b1;
        applyStimulus("stretch held", 7'h33, 1, 1, 0, 0);
        checkOutput("stretch extension", lastCycles - baseCycles, 20);
`endif

        checkOutput("pops on empty FIFO", badPop, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
